fifo_fill_ctrl: RTL and testbench

//  Upstream fill/drain controller for the 64-bit delay-buffer fifo. Accepts words over a valid/ready

---
 rtl/fifo_fill_ctrl_pkg.sv | 21 ++
 rtl/fifo_fill_ctrl_if.sv | 30 +++
 rtl/fifo.sv | 26 ++
 rtl/fifo_fill_ctrl.sv | 154 +++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_fill_ctrl_pkg.sv
// Shared types and defaults for the delay-buffer fifo fill/drain controller,
// the fifo itself and the bench.
package fifo_fill_ctrl_pkg;

    // Block geometry shared with the fifo.
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_BITS  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fill_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_fill_ctrl_if.sv
// Producer/consumer-facing bundle of the fill controller: input handshake,
// drain request, fifo drive and status.
interface fifo_fill_ctrl_if
    import fifo_fill_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BITS-1:0]           in_data;
    logic                      drain_req;
    logic                      fifo_en;
    logic [BITS-1:0]           fifo_d;
    logic                      full;
    logic                      q_pop;
    logic [cnt_w(DEPTH)-1:0]   fill_cnt;

    // Producer / consumer side.
    modport master (
        output in_valid, in_data, drain_req,
        input  in_ready, fifo_en, fifo_d, full, q_pop, fill_cnt
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, drain_req,
        output in_ready, fifo_en, fifo_d, full, q_pop, fill_cnt
    );
endinterface

// File: rtl/fifo.sv
// Delay-buffer fifo: a DEPTH-stage shift register. Every enabled edge shifts
// d in at stage 0; q is the last stage, i.e. the oldest of the last DEPTH words.
module fifo
    import fifo_fill_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);
    logic [DEPTH-1:0][BITS-1:0] r_mem;

    // Shift register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mem <= '0;
        else if (en)
            r_mem <= {r_mem[DEPTH-2:0], d};
    end

    assign q = r_mem[DEPTH-1];
endmodule

// File: rtl/fifo_fill_ctrl.sv
// Fill/drain controller for the delay-buffer fifo. Loads exactly DEPTH words
// through a valid/ready handshake, reports the block full, then shifts it out
// oldest-first on a drain request.
// Optional feature: OVERLAP_LOAD_EN. When defined, the drain is lockstep with
// the producer: each accepted word both pops the oldest word and refills it,
// and the block returns to FULL. When undefined, the drain shifts zeros in
// every cycle and the controller returns to IDLE.
module fifo_fill_ctrl
    import fifo_fill_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_fill_ctrl_if.slave      bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int DW = $clog2(DEPTH);

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic [CW-1:0]     r_fill_cnt;
    logic [CW-1:0]     w_fill_nxt;
    logic [DW-1:0]     r_drain_cnt;
    logic [DW-1:0]     w_drain_nxt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_full;
    logic              w_q_pop;
    logic              w_fifo_en;
    logic [BITS-1:0]   w_fifo_d;

    // State and counters; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fill_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Ready depends only on state, so accept can be formed without a loop.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            FILL:    w_in_ready = 1'b1;
            FULL:    w_in_ready = 1'b0;
`ifdef OVERLAP_LOAD_EN
            DRAIN:   w_in_ready = 1'b1;
`else
            DRAIN:   w_in_ready = 1'b0;
`endif
            default: w_in_ready = 1'b0;
        endcase
        // Reset value is visible in the very first reset cycle.
        if (rst)
            w_in_ready = 1'b1;
    end

    assign w_accept = bus.in_valid & w_in_ready & ~rst;

    // Next state, counters and fifo drive.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_drain_nxt = r_drain_cnt;
        w_full      = 1'b0;
        w_q_pop     = 1'b0;
        w_fifo_en   = 1'b0;
        w_fifo_d    = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_fifo_en   = 1'b1;
                    w_fifo_d    = bus.in_data;
                    w_fill_nxt  = CW'(1);
                    w_state_nxt = FILL;
                end
            end

            FILL: begin
                if (w_accept) begin
                    w_fifo_en  = 1'b1;
                    w_fifo_d   = bus.in_data;
                    w_fill_nxt = r_fill_cnt + CW'(1);
                    if (r_fill_cnt == CW'(DEPTH - 1))
                        w_state_nxt = FULL;
                end
            end

            FULL: begin
                // drain_req is a level; it only matters once the block is full.
                w_full = 1'b1;
                if (bus.drain_req) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                end
            end

            DRAIN: begin
`ifdef OVERLAP_LOAD_EN
                // One pop per accepted word; the block stays DEPTH deep.
                if (w_accept) begin
                    w_fifo_en = 1'b1;
                    w_q_pop   = 1'b1;
                    w_fifo_d  = bus.in_data;
                    if (r_drain_cnt == DW'(DEPTH - 1)) begin
                        w_drain_nxt = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_drain_nxt = r_drain_cnt + DW'(1);
                    end
                end
`else
                // Free-running shift, zeros back-fill the fifo.
                w_fifo_en  = 1'b1;
                w_q_pop    = 1'b1;
                w_fill_nxt = r_fill_cnt - CW'(1);
                if (r_drain_cnt == DW'(DEPTH - 1)) begin
                    w_drain_nxt = '0;
                    w_fill_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_nxt = r_drain_cnt + DW'(1);
                end
`endif
            end

            default: w_state_nxt = IDLE;
        endcase

        if (rst) begin
            w_full    = 1'b0;
            w_q_pop   = 1'b0;
            w_fifo_en = 1'b0;
            w_fifo_d  = '0;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.full     = w_full;
    assign bus.q_pop    = w_q_pop;
    assign bus.fifo_en  = w_fifo_en;
    assign bus.fifo_d   = w_fifo_d;
    assign bus.fill_cnt = rst ? '0 : r_fill_cnt;
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench: fifo_fill_ctrl driving the delay-buffer fifo (DEPTH=8, BITS=64).
module tb_fifo_fill_ctrl;
    import fifo_fill_ctrl_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int BITS  = DEFAULT_BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] q;
    int              n_assert = 0;
    int              n_fail   = 0;
    int              n_en;

    fifo_fill_ctrl_if #(.DEPTH(DEPTH), .BITS(BITS)) ifc ();

    fifo_fill_ctrl #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    fifo #(.DEPTH(DEPTH), .BITS(BITS)) u_fifo (
        .clk   (clk),
        .rst_n (~rst),
        .en    (ifc.fifo_en),
        .d     (ifc.fifo_d),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push DEPTH words base, base+1, ... back to back; ends one cycle after the last accept.
    task automatic push_block(input logic [63:0] base, input logic dreq);
        for (int i = 0; i < DEPTH; i++) begin
            ifc.in_valid  = 1'b1;
            ifc.in_data   = base + 64'(i);
            ifc.drain_req = dreq;
            settle();
            chk("fill_ready", 64'(ifc.in_ready), 64'd1);
            chk("fill_en",    64'(ifc.fifo_en),  64'd1);
            chk("fill_d",     ifc.fifo_d,        base + 64'(i));
            chk("fill_cnt",   64'(ifc.fill_cnt), 64'(i));
            chk("fill_nofull",64'(ifc.full),     64'd0);
            chk("fill_nopop", 64'(ifc.q_pop),    64'd0);
            tick();
        end
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

`ifndef OVERLAP_LOAD_EN
    // From FULL: pulse drain_req, expect DEPTH consecutive pops of base..base+7, then IDLE.
    task automatic drain_block(input logic [63:0] base);
        ifc.drain_req = 1'b1;
        settle();
        chk("pre_drain_pop", 64'(ifc.q_pop), 64'd0);
        tick();
        ifc.drain_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            chk("drain_pop",   64'(ifc.q_pop),    64'd1);
            chk("drain_q",     q,                 base + 64'(k));
            chk("drain_cnt",   64'(ifc.fill_cnt), 64'(DEPTH - k));
            chk("drain_ready", 64'(ifc.in_ready), 64'd0);
            chk("drain_d",     ifc.fifo_d,        64'd0);
            tick();
        end
        settle();
        chk("post_drain_pop",   64'(ifc.q_pop),    64'd0);
        chk("post_drain_cnt",   64'(ifc.fill_cnt), 64'd0);
        chk("post_drain_q",     q,                 64'd0);
        chk("post_drain_ready", 64'(ifc.in_ready), 64'd1);
        chk("post_drain_full",  64'(ifc.full),     64'd0);
    endtask
`endif

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.drain_req = 1'b0;
        settle();
        // Reset values held from the first reset cycle.
        chk("rst_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_full",  64'(ifc.full),     64'd0);
        chk("rst_pop",   64'(ifc.q_pop),    64'd0);
        chk("rst_en",    64'(ifc.fifo_en),  64'd0);
        chk("rst_d",     ifc.fifo_d,        64'd0);
        chk("rst_cnt",   64'(ifc.fill_cnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_q", q, 64'd0);

        // 1: reset mid-FILL after three words.
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 64'hA1 + 64'(i);
            tick();
        end
        ifc.in_valid = 1'b0;
        settle();
        chk("t1_cnt3", 64'(ifc.fill_cnt), 64'd3);
        chk("t1_d_idle", ifc.fifo_d, 64'd0);
        rst = 1'b1;
        settle();
        chk("t1_rst_cnt",   64'(ifc.fill_cnt), 64'd0);
        chk("t1_rst_ready", 64'(ifc.in_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("t1_ready", 64'(ifc.in_ready), 64'd1);
        chk("t1_full",  64'(ifc.full),     64'd0);
        chk("t1_cnt",   64'(ifc.fill_cnt), 64'd0);
        chk("t1_q",     q,                 64'd0);

        // 2: load 0x11..0x18 back to back.
        push_block(64'h11, 1'b0);
        settle();
        chk("t2_full",  64'(ifc.full),     64'd1);
        chk("t2_cnt",   64'(ifc.fill_cnt), 64'd8);
        chk("t2_q",     q,                 64'h11);
        chk("t2_ready", 64'(ifc.in_ready), 64'd0);
        chk("t2_en",    64'(ifc.fifo_en),  64'd0);

`ifndef OVERLAP_LOAD_EN
        // 3: one-cycle drain pulse, zeros shifted in.
        drain_block(64'h11);
`else
        // 6: lockstep drain while loading 0x21..0x28 with one idle gap.
        ifc.drain_req = 1'b1;
        tick();
        ifc.drain_req = 1'b0;
        begin
            int w;
            w = 0;
            for (int c = 0; c < DEPTH + 1; c++) begin
                ifc.in_valid = (c != 3);
                ifc.in_data  = ifc.in_valid ? 64'h21 + 64'(w) : 64'hDEAD;
                settle();
                chk("t6_ready", 64'(ifc.in_ready), 64'd1);
                chk("t6_pop",   64'(ifc.q_pop),    64'(ifc.in_valid));
                chk("t6_q",     q,                 64'h11 + 64'(w));
                chk("t6_cnt",   64'(ifc.fill_cnt), 64'd8);
                chk("t6_nofull",64'(ifc.full),     64'd0);
                if (ifc.in_valid) w++;
                tick();
            end
        end
        ifc.in_valid = 1'b0;
        settle();
        chk("t6_full", 64'(ifc.full),     64'd1);
        chk("t6_q21",  q,                 64'h21);
        chk("t6_cnt8", 64'(ifc.fill_cnt), 64'd8);
        do_reset();
`endif

        // 4: in_valid alternating 1/0: 8 words in 15 cycles.
        n_en = 0;
        for (int c = 0; c < 2 * DEPTH - 1; c++) begin
            ifc.in_valid = (c % 2 == 0);
            ifc.in_data  = ifc.in_valid ? 64'h31 + 64'(c / 2) : 64'hBAD;
            settle();
            chk("t4_nofull", 64'(ifc.full), 64'd0);
            if (ifc.fifo_en) n_en++;
            tick();
        end
        ifc.in_valid = 1'b0;
        settle();
        chk("t4_en_count", 64'(n_en),         64'd8);
        chk("t4_full",     64'(ifc.full),     64'd1);
        chk("t4_q",        q,                 64'h31);
`ifndef OVERLAP_LOAD_EN
        drain_block(64'h31);
`else
        do_reset();
`endif

        // 5: drain_req held during FILL and while in_valid=1 in FULL.
        push_block(64'h41, 1'b1);
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 64'hEE;
        ifc.drain_req = 1'b1;
        settle();
        chk("t5_full",  64'(ifc.full),     64'd1);
        chk("t5_ready", 64'(ifc.in_ready), 64'd0);
        chk("t5_en",    64'(ifc.fifo_en),  64'd0);
        chk("t5_d",     ifc.fifo_d,        64'd0);
        chk("t5_pop",   64'(ifc.q_pop),    64'd0);
        chk("t5_q",     q,                 64'h41);
`ifndef OVERLAP_LOAD_EN
        tick();
        ifc.drain_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            chk("t5_drain_ready", 64'(ifc.in_ready), 64'd0);
            chk("t5_drain_d",     ifc.fifo_d,        64'd0);
            chk("t5_drain_q",     q,                 64'h41 + 64'(k));
            tick();
        end
        ifc.in_valid = 1'b0;
        settle();
        chk("t5_end_cnt", 64'(ifc.fill_cnt), 64'd0);
        chk("t5_end_q",   q,                 64'd0);
`else
        ifc.in_valid  = 1'b0;
        ifc.drain_req = 1'b0;
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
